// File: rtl/scratchpad_seq.sv
// ============================================================================
//  Module   : scratchpad_seq
//  Function : scrypt scratchpad sequencer; fills V[0..N-1] from the core's X
//             words, then returns V[j] for each integerified X word.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module scratchpad_seq #(
    parameter int ADDRBITS = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [255:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [255:0]        out_data,
    output logic [ADDRBITS-1:0] ram_raddr,
    output logic [ADDRBITS-1:0] ram_waddr,
    output logic [255:0]        ram_data,
    output logic                ram_wren,
    input  logic [255:0]        ram_q
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WRITE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_READ  = 2'd3;

    localparam logic [ADDRBITS-1:0] c_LAST = '1;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [ADDRBITS-1:0] r_wcount;
    logic [ADDRBITS-1:0] r_rcount;
    logic [ADDRBITS-1:0] r_rd_addr;
    logic                r_rd_pend;
    logic                r_rd_phase;
    logic                r_out_valid;
    logic [255:0]        r_out_data;
    logic                r_wren;
    logic [255:0]        r_wdata;
    logic                r_done;
    logic                w_in_ready;
    logic                w_in_beat;
    logic                w_out_beat;

    assign w_in_ready = (r_state == c_WRITE) ||
                        ((r_state == c_READ) && !r_rd_pend && !r_out_valid);
    assign w_in_beat  = in_valid && w_in_ready;
    assign w_out_beat = r_out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = c_WRITE;
            c_WRITE: if (w_in_beat && (r_wcount == c_LAST)) w_state_nxt = c_DRAIN;
            c_DRAIN: w_state_nxt = c_READ;
            c_READ:  if (w_out_beat && (r_rcount == c_LAST)) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // The RAM registers waddr itself, so the data/wren pair is delayed one
    // cycle to line up with the old wcount it latched on the beat edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wcount    <= '0;
            r_rcount    <= '0;
            r_rd_addr   <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_phase  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_wren      <= 1'b0;
            r_wdata     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_wcount <= '0;
                        r_rcount <= '0;
                    end
                end
                c_WRITE: begin
                    if (w_in_beat) begin
                        r_wcount <= r_wcount + 1'b1;
                        r_wren   <= 1'b1;
                        r_wdata  <= in_data;
                    end
                end
                c_READ: begin
                    if (w_in_beat) begin
                        r_rd_addr  <= in_data[ADDRBITS-1:0];
                        r_rd_pend  <= 1'b1;
                        r_rd_phase <= 1'b0;
                    end else if (r_rd_pend) begin
                        // phase 0: RAM latches raddr; phase 1: ram_q is valid
                        if (!r_rd_phase) begin
                            r_rd_phase <= 1'b1;
                        end else begin
                            r_out_data  <= ram_q;
                            r_out_valid <= 1'b1;
                            r_rd_pend   <= 1'b0;
                        end
                    end
                    if (w_out_beat) begin
                        r_out_valid <= 1'b0;
                        r_rcount    <= r_rcount + 1'b1;
                        if (r_rcount == c_LAST) r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != c_IDLE);
    assign done      = r_done;
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign ram_raddr = r_rd_addr;
    assign ram_waddr = r_wcount;
    assign ram_data  = r_wdata;
    assign ram_wren  = r_wren;

endmodule

`default_nettype wire

// File: tb/tb_scratchpad_seq.sv
// ============================================================================
//  Module   : tb_scratchpad_seq
//  Function : Self-checking bench for scratchpad_seq with a registered-address
//             RAM model and an array-based reference of the scratchpad.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_scratchpad_seq;

    localparam int ADDRBITS = 4;
    localparam int N        = 16;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                busy, done;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [255:0]        in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [255:0]        out_data;
    logic [ADDRBITS-1:0] ram_raddr, ram_waddr;
    logic [255:0]        ram_data;
    logic                ram_wren;
    logic [255:0]        ram_q;

    scratchpad_seq #(.ADDRBITS(ADDRBITS)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_data(ram_data),
        .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    // RAM with registered read and write addresses, unregistered data/wren
    logic [255:0]        mem [N];
    logic [ADDRBITS-1:0] raddr_q, waddr_q;
    always @(posedge clock) begin
        raddr_q <= ram_raddr;
        waddr_q <= ram_waddr;
        if (ram_wren) mem[waddr_q] <= ram_data;
    end
    assign ram_q = mem[raddr_q];

    int done_cnt = 0;
    always @(posedge clock) if (done) done_cnt <= done_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    int n_pass  = 0;
    int n_total = 0;
    logic [255:0] model_v [N];

    typedef struct {
        logic [3:0]   j;
        logic [255:0] exp;
        int           stall;
    } vec_t;
    vec_t tbl [N];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_in_ready"},  in_ready,  0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_ram_wren"},  ram_wren,  0);
        chk({tag, "_out_data"},  out_data,  0);
        chk({tag, "_ram_data"},  ram_data,  0);
        chk({tag, "_ram_raddr"}, ram_raddr, 0);
        chk({tag, "_ram_waddr"}, ram_waddr, 0);
    endtask

    task automatic wait_in_ready(input string name);
        int k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        chk(name, in_ready, 1);
    endtask

    // Fills V[0..N-1]; abort_at < N asserts reset the cycle after beat abort_at-1.
    task automatic write_all(input bit gapped, input bit poke, input bit fixed, input int abort_at);
        int wren_cnt = 0;
        logic [255:0] d;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wr_busy", busy, 1);
        wren_cnt += int'(ram_wren);
        for (int i = 0; i < N; i++) begin
            if (i == abort_at) begin
                chk("abort_wren_before", ram_wren, 1);
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk_reset_outputs("rst_wr");
                for (int k = 0; k < 4; k++) begin
                    tick();
                    chk("rst_wr_quiet", {out_valid, ram_wren, busy}, 0);
                end
                return;
            end
            if (gapped) begin
                in_valid = 1'b0;
                tick();
                chk("gap_wren", ram_wren, 0);
                wren_cnt += int'(ram_wren);
            end
            d = fixed ? 256'(32'hA000 + i) : {8{$urandom}};
            model_v[i] = d;
            in_data  = d;
            in_valid = 1'b1;
            if (poke && i == 5) start = 1'b1;
            chk("wr_in_ready", in_ready, 1);
            chk("wr_waddr", ram_waddr, i);
            tick();
            start = 1'b0;
            chk("wr_wren_lag", ram_wren, 1);
            chk("wr_data", ram_data, d);
            wren_cnt += int'(ram_wren);
        end
        in_valid = 1'b0;
        chk("drain_in_ready", in_ready, 0);
        chk("drain_busy", busy, 1);
        tick();
        chk("read_in_ready", in_ready, 1);
        chk("read_wren", ram_wren, 0);
        wren_cnt += int'(ram_wren);
        chk("wren_cycles", wren_cnt, N);
        for (int i = 0; i < N; i++) chk("ram_contents", mem[i], model_v[i]);
    endtask

    task automatic read_one(input logic [3:0] j, input logic [255:0] exp, input int stall,
                            input bit last, input bit poke);
        int n;
        logic [255:0] held;
        logic [255:0] r;
        wait_in_ready("rd_in_ready");
        r = {8{$urandom}};
        r[3:0] = j;
        in_data  = r;
        in_valid = 1'b1;
        if (poke) start = 1'b1;
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
        chk("rd_raddr", ram_raddr, j);
        n = 1;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("rd_latency", n, 3);
        chk("rd_data", out_data, exp);
        held = out_data;
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("bp_hold", {out_valid, in_ready, out_data}, {1'b1, 1'b0, held});
            chk("bp_raddr", ram_raddr, j);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("rd_out_valid_clr", out_valid, 0);
        chk("rd_done", done, last);
        if (last) begin
            chk("done_busy", busy, 0);
            tick();
            chk("done_pulse_end", done, 0);
        end
    endtask

    task automatic random_reads(input bit poke);
        int d0 = done_cnt;
        logic [3:0] j;
        for (int k = 0; k < N; k++) begin
            j = 4'($urandom_range(0, N - 1));
            read_one(j, model_v[j], (k == 4) ? 2 : 0, k == N - 1, poke && k == 7);
        end
        tick();
        chk("done_once", done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        tbl[0]  = '{4'd3,  256'hA003, 0};
        tbl[1]  = '{4'd15, 256'hA00F, 0};
        tbl[2]  = '{4'd0,  256'hA000, 0};
        tbl[3]  = '{4'd3,  256'hA003, 0};
        tbl[4]  = '{4'd1,  256'hA001, 0};
        tbl[5]  = '{4'd2,  256'hA002, 5};
        tbl[6]  = '{4'd4,  256'hA004, 0};
        tbl[7]  = '{4'd5,  256'hA005, 0};
        tbl[8]  = '{4'd6,  256'hA006, 0};
        tbl[9]  = '{4'd7,  256'hA007, 0};
        tbl[10] = '{4'd8,  256'hA008, 0};
        tbl[11] = '{4'd9,  256'hA009, 0};
        tbl[12] = '{4'd10, 256'hA00A, 0};
        tbl[13] = '{4'd11, 256'hA00B, 0};
        tbl[14] = '{4'd14, 256'hA00E, 0};
        tbl[15] = '{4'd13, 256'hA00D, 0};

        tick();
        tick();
        reset = 1'b0;
        chk_reset_outputs("por");

        // fixed pattern hash, table-driven reads with backpressure
        write_all(1'b0, 1'b0, 1'b1, N);
        d0 = done_cnt;
        for (int i = 0; i < N; i++) read_one(tbl[i].j, tbl[i].exp, tbl[i].stall, i == N - 1, 1'b0);
        tick();
        chk("done_once_tbl", done_cnt - d0, 1);

        // gapped writes, start pulses ignored in WRITE and READ
        write_all(1'b1, 1'b1, 1'b0, N);
        random_reads(1'b1);

        // reset mid-WRITE, then a full hash
        write_all(1'b0, 1'b0, 1'b0, 7);
        write_all(1'b0, 1'b0, 1'b0, N);
        random_reads(1'b0);

        // reset with a read pending, then a full hash
        write_all(1'b0, 1'b0, 1'b0, N);
        wait_in_ready("rp_in_ready");
        in_data  = 256'h5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_outputs("rst_rd");
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rst_rd_no_out", out_valid, 0);
        end
        write_all(1'b1, 1'b0, 1'b0, N);
        random_reads(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scratchpad_seq.md
# scratchpad_seq

Sequencer that owns both ports of the scrypt scratchpad RAM (256-bit words, 2^ADDRBITS entries, registered read and write addresses). It sits between the salsa mixing core and the RAM. In phase 1 it writes the core's successive X words to V[0..N-1]. In phase 2 it reads V[j], where j is integerified from each new X word, and returns the result to the core. It is the driving end of the RAM's raddr/waddr/data/wren/q interface and absorbs that RAM's asymmetric write timing.

## Interface
- ADDRBITS, 10, scratchpad address width; N = 2^ADDRBITS entries.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; starts a hash. Honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the Nth read result is accepted.
- in_valid  in  1  core presents an X word.
- in_ready  out  1  sequencer accepts the word. A beat occurs when in_valid & in_ready.
- in_data  in  256  X word from the core.
- out_valid  out  1  V[j] word available.
- out_ready  in  1  core accepts it. A beat occurs when out_valid & out_ready.
- out_data  out  256  V[j] word; held stable while out_valid.
- ram_raddr  out  ADDRBITS  to RAM read address (RAM registers it).
- ram_waddr  out  ADDRBITS  to RAM write address (RAM registers it).
- ram_data  out  256  to RAM write data (sampled unregistered, with ram_wren).
- ram_wren  out  1  to RAM write enable.
- ram_q  in  256  RAM read data; valid the cycle after ram_raddr is presented.

## Operation
- States: IDLE, WRITE, DRAIN, READ.
- IDLE
  - start=1 -> WRITE; wcount=0, rcount=0.
  - start while busy is ignored.
- WRITE
  - in_ready=1.
  - ram_waddr = wcount, driven continuously from a register.
  - On an in beat in cycle t:
    - wcount <= wcount+1.
    - At t+1: ram_wren=1 and ram_data = in_data captured at t.
    - The RAM's internal waddr register holds the old wcount during t+1, so V[i] is written at the end of t+1.
  - On the beat with wcount == N-1 -> DRAIN. wcount wraps to 0.
- DRAIN
  - One cycle; in_ready=0. The final write commits during this cycle. Then -> READ.
- READ
  - in_ready = !rd_pend & !out_valid.
  - On an in beat at t:
    - j = in_data[ADDRBITS-1:0]; rd_addr <= j; rd_pend <= 1.
    - ram_raddr = rd_addr, driven from a register, so the RAM captures j at the end of t+1.
    - ram_q is valid at t+2. out_data <= ram_q at the end of t+2, rd_pend <= 0, out_valid=1 from t+3.
  - On an out beat: out_valid <= 0; rcount <= rcount+1.
  - On the out beat with rcount == N-1: done=1 for the next cycle; -> IDLE.
- At most one read is outstanding. ram_wren=0 in every state except the cycle after a WRITE beat.
- reset (any state, including mid-WRITE or with a read pending):
  - -> IDLE; wcount, rcount, rd_pend, rd_addr all cleared.
  - Any captured write is dropped: ram_wren=0 from the first edge with reset high.
  - RAM contents are not cleared.

## Timing
- Reset values:
  - busy, done, in_ready, out_valid, ram_wren = 0.
  - out_data, ram_data, ram_raddr, ram_waddr = 0.
- Write path:
  - Beat at t -> RAM store updated at the end of t+1.
  - Throughput is 1 word/cycle; back-to-back beats give ram_wren high continuously.
- Phase turnaround: last WRITE beat at t, DRAIN at t+1, first READ in_ready at t+2.
- Read path:
  - in beat at t -> out_valid at t+3.
  - With out_ready held high, the next in_ready is at t+4, giving 1 read per 4 cycles.
- Read-during-write cannot occur; DRAIN guarantees it.
- done is asserted the cycle after the final out beat; busy falls in the same cycle.

## Test plan
- ADDRBITS=4:
  - Stimulus: start, then 16 WRITE beats with in_data = 256'hA000+i, no gaps.
  - Required: ram_wren high for exactly 16 cycles, each lagging its beat by 1. The model RAM holds V[i] = 'hA000+i. State is DRAIN for exactly 1 cycle, then in_ready rises.
- READ, ADDRBITS=4:
  - Stimulus: in_data low nibbles 3, 15, 0, 3, ... with out_ready=1.
  - Required: out_data = 'hA003, 'hA00F, 'hA000, 'hA003. Each out_valid appears exactly 3 cycles after its in beat. A single done pulse follows the 16th out beat.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles with out_valid=1.
  - Required: out_data stable, in_ready=0, no ram_raddr change, rcount unchanged.
- Gapped writes:
  - Stimulus: toggle in_valid every other cycle during WRITE.
  - Required: ram_wren pulses only after beats. All 16 entries are correct and none is skipped or duplicated.
- Reset mid-operation:
  - Stimulus: reset during WRITE at wcount=7, the cycle after a beat; separately, reset during READ with a read pending.
  - Required: all outputs reach their reset values next cycle, ram_wren=0, no out_valid appears. A subsequent start runs a complete, correct hash.
- start ignored:
  - Stimulus: pulse start during WRITE and during READ.
  - Required: wcount and rcount are not reset; done still appears exactly once.
